// File: rtl/id_exe_if.sv
// id_exe_if: ID-side inputs and EXE-side registered outputs of the ID/EXE pipeline register
interface id_exe_if #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int ALUOP_W = 5,
    parameter int CNT_W   = 16
);
    logic               id_valid;
    logic [DATA_W-1:0]  id_pc, id_reg1_data, id_reg2_data, id_sw_data, id_imm;
    logic [ADDR_W-1:0]  id_reg1_addr, id_reg2_addr, id_sw_addr, id_write_addr;
    logic               id_reg1_read, id_reg2_read, id_sw_read;
    logic               id_reg_write, id_dm_read, id_dm_write, id_movsrc, id_alusrc;
    logic [ALUOP_W-1:0] id_alu_op;
    logic               exe_stall, flush;
    logic               exe_valid;
    logic [DATA_W-1:0]  exe_pc, exe_reg1_data, exe_reg2_data, exe_sw_data, exe_imm;
    logic [ADDR_W-1:0]  exe_write_addr;
    logic               exe_reg_write, exe_dm_read, exe_dm_write, exe_movsrc, exe_alusrc;
    logic [ALUOP_W-1:0] exe_alu_op;
    logic               stall_pc, stall_if_id;
    logic [CNT_W-1:0]   bubble_cnt;

    modport master (
        output id_valid, id_pc, id_reg1_data, id_reg2_data, id_sw_data, id_imm,
               id_reg1_addr, id_reg2_addr, id_sw_addr, id_write_addr,
               id_reg1_read, id_reg2_read, id_sw_read,
               id_reg_write, id_dm_read, id_dm_write, id_movsrc, id_alusrc, id_alu_op,
               exe_stall, flush,
        input  exe_valid, exe_pc, exe_reg1_data, exe_reg2_data, exe_sw_data, exe_imm,
               exe_write_addr, exe_reg_write, exe_dm_read, exe_dm_write, exe_movsrc,
               exe_alusrc, exe_alu_op, stall_pc, stall_if_id, bubble_cnt
    );

    modport slave (
        input  id_valid, id_pc, id_reg1_data, id_reg2_data, id_sw_data, id_imm,
               id_reg1_addr, id_reg2_addr, id_sw_addr, id_write_addr,
               id_reg1_read, id_reg2_read, id_sw_read,
               id_reg_write, id_dm_read, id_dm_write, id_movsrc, id_alusrc, id_alu_op,
               exe_stall, flush,
        output exe_valid, exe_pc, exe_reg1_data, exe_reg2_data, exe_sw_data, exe_imm,
               exe_write_addr, exe_reg_write, exe_dm_read, exe_dm_write, exe_movsrc,
               exe_alusrc, exe_alu_op, stall_pc, stall_if_id, bubble_cnt
    );
endinterface

// File: rtl/id_exe_stage.sv
// id_exe_stage: ID/EXE pipeline register with load-use bubble insertion, stall/flush and bubble counter
module id_exe_stage (
    input logic   clk,
    input logic   rst,
    id_exe_if.slave bus
);
    localparam int DATA_W  = $bits(bus.id_pc);
    localparam int ADDR_W  = $bits(bus.id_write_addr);
    localparam int ALUOP_W = $bits(bus.id_alu_op);
    localparam int CNT_W   = $bits(bus.bubble_cnt);

    typedef struct packed {
        logic [DATA_W-1:0]  pc;
        logic [DATA_W-1:0]  reg1_data;
        logic [DATA_W-1:0]  reg2_data;
        logic [DATA_W-1:0]  sw_data;
        logic [DATA_W-1:0]  imm;
        logic [ADDR_W-1:0]  write_addr;
        logic [ALUOP_W-1:0] alu_op;
        logic               movsrc;
        logic               alusrc;
    } payload_t;

    typedef struct packed {
        logic valid;
        logic reg_write;
        logic dm_read;
        logic dm_write;
    } ctrl_t;

    payload_t         payload_d, payload_q;
    ctrl_t            ctrl_d, ctrl_q;
    logic [CNT_W-1:0] bubble_cnt_d, bubble_cnt_q;
    logic             lu, stall;

    // Hazard detection against the load in EXE, then next-state selection: flush > exe_stall > bubble > capture
    always_comb begin
        lu = ctrl_q.valid & ctrl_q.dm_read & ctrl_q.reg_write & bus.id_valid &
             ((bus.id_reg1_read & (bus.id_reg1_addr == payload_q.write_addr)) |
              (bus.id_reg2_read & (bus.id_reg2_addr == payload_q.write_addr)) |
              (bus.id_sw_read   & (bus.id_sw_addr   == payload_q.write_addr)));
        stall = ~bus.flush & (bus.exe_stall | lu);
        payload_d = payload_q;
        ctrl_d = ctrl_q;
        bubble_cnt_d = bubble_cnt_q;
        if (bus.flush) begin
            ctrl_d = '0;
        end else if (!bus.exe_stall && lu) begin
            ctrl_d = '0;
            bubble_cnt_d = &bubble_cnt_q ? bubble_cnt_q : bubble_cnt_q + CNT_W'(1);
        end else if (!bus.exe_stall) begin
            payload_d = '{pc: bus.id_pc, reg1_data: bus.id_reg1_data, reg2_data: bus.id_reg2_data,
                          sw_data: bus.id_sw_data, imm: bus.id_imm, write_addr: bus.id_write_addr,
                          alu_op: bus.id_alu_op, movsrc: bus.id_movsrc & bus.id_valid,
                          alusrc: bus.id_alusrc & bus.id_valid};
            ctrl_d = '{valid: bus.id_valid, reg_write: bus.id_reg_write & bus.id_valid,
                       dm_read: bus.id_dm_read & bus.id_valid, dm_write: bus.id_dm_write & bus.id_valid};
        end
    end

    // Pipeline register and bubble counter
    always_ff @(posedge clk) begin
        if (rst) begin
            payload_q    <= '0;
            ctrl_q       <= '0;
            bubble_cnt_q <= '0;
        end else begin
            payload_q    <= payload_d;
            ctrl_q       <= ctrl_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign bus.exe_valid      = ctrl_q.valid;
    assign bus.exe_reg_write  = ctrl_q.reg_write;
    assign bus.exe_dm_read    = ctrl_q.dm_read;
    assign bus.exe_dm_write   = ctrl_q.dm_write;
    assign bus.exe_pc         = payload_q.pc;
    assign bus.exe_reg1_data  = payload_q.reg1_data;
    assign bus.exe_reg2_data  = payload_q.reg2_data;
    assign bus.exe_sw_data    = payload_q.sw_data;
    assign bus.exe_imm        = payload_q.imm;
    assign bus.exe_write_addr = payload_q.write_addr;
    assign bus.exe_alu_op     = payload_q.alu_op;
    assign bus.exe_movsrc     = payload_q.movsrc;
    assign bus.exe_alusrc     = payload_q.alusrc;
    assign bus.stall_pc       = stall;
    assign bus.stall_if_id    = stall;
    assign bus.bubble_cnt     = bubble_cnt_q;
endmodule

// File: tb/tb_id_exe_stage.sv
// tb_id_exe_stage: scoreboard bench for the ID/EXE pipeline register (4-bit counter so saturation is reachable)
module tb_id_exe_stage;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc, r1, r2, sw, imm;
        logic [4:0]  wa, op;
        logic        rw, dr, dw, mov, als;
        logic [3:0]  cnt;
    } exp_t;

    exp_t  sb[$];
    string names[$];
    exp_t  last, mon_w, mon_g;
    string mon_n;
    logic [3:0] exp_cnt;

    id_exe_if #(.CNT_W(4)) bus ();
    id_exe_stage dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    function automatic exp_t obs();
        return '{bus.exe_valid, bus.exe_pc, bus.exe_reg1_data, bus.exe_reg2_data, bus.exe_sw_data,
                 bus.exe_imm, bus.exe_write_addr, bus.exe_alu_op, bus.exe_reg_write, bus.exe_dm_read,
                 bus.exe_dm_write, bus.exe_movsrc, bus.exe_alusrc, bus.bubble_cnt};
    endfunction

    function automatic exp_t from_id();
        logic v = bus.id_valid;
        return '{v, bus.id_pc, bus.id_reg1_data, bus.id_reg2_data, bus.id_sw_data, bus.id_imm,
                 bus.id_write_addr, bus.id_alu_op, bus.id_reg_write & v, bus.id_dm_read & v,
                 bus.id_dm_write & v, bus.id_movsrc & v, bus.id_alusrc & v, exp_cnt};
    endfunction

    function automatic exp_t kill(input exp_t e);
        e.valid = 1'b0; e.rw = 1'b0; e.dr = 1'b0; e.dw = 1'b0; e.cnt = exp_cnt;
        return e;
    endfunction

    task automatic push(input exp_t e, input string n);
        sb.push_back(e);
        names.push_back(n);
        last = e;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bump();
        exp_cnt = (exp_cnt == 4'hF) ? 4'hF : exp_cnt + 4'd1;
    endtask

    task automatic instr(input logic v, input logic [31:0] pc, input logic [4:0] wa,
                         input logic rw, input logic dr, input logic dw);
        bus.id_valid = v; bus.id_pc = pc;
        bus.id_reg1_data = pc ^ 32'h1111_0000; bus.id_reg2_data = pc ^ 32'h2222_0000;
        bus.id_sw_data = pc ^ 32'h3333_0000; bus.id_imm = pc ^ 32'h4444_0000;
        bus.id_write_addr = wa; bus.id_reg_write = rw; bus.id_dm_read = dr; bus.id_dm_write = dw;
        bus.id_alu_op = pc[6:2]; bus.id_movsrc = pc[2]; bus.id_alusrc = pc[3];
        bus.id_reg1_addr = '0; bus.id_reg2_addr = '0; bus.id_sw_addr = '0;
        bus.id_reg1_read = 1'b0; bus.id_reg2_read = 1'b0; bus.id_sw_read = 1'b0;
    endtask

    task automatic src(input int s, input logic [4:0] a);
        if (s == 0) begin bus.id_reg1_addr = a; bus.id_reg1_read = 1'b1; end
        else if (s == 1) begin bus.id_reg2_addr = a; bus.id_reg2_read = 1'b1; end
        else begin bus.id_sw_addr = a; bus.id_sw_read = 1'b1; end
    endtask

    // Scoreboard: one expected entry is consumed per edge after which the bench queued one
    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            mon_w = sb.pop_front();
            mon_n = names.pop_front();
            mon_g = obs();
            checks++;
            if (mon_g !== mon_w) begin
                errors++;
                $display("FAIL %s: got %h want %h", mon_n, mon_g, mon_w);
            end
        end
    end

    task automatic test_reset();
        instr(1'b1, 32'hDEAD_BEE0, 5'd7, 1'b1, 1'b1, 1'b1);
        bus.exe_stall = 1'b0; bus.flush = 1'b0; rst = 1'b1;
        tick(); tick();
        checks++;
        if (obs() !== '0) begin errors++; $display("FAIL reset_state: got %h want 0", obs()); end
        checks++;
        if (bus.stall_pc !== 1'b0 || bus.stall_if_id !== 1'b0) begin
            errors++; $display("FAIL reset_stall: got %b%b want 00", bus.stall_pc, bus.stall_if_id);
        end
        rst = 1'b0; exp_cnt = '0; last = '0;
    endtask

    task automatic test_capture();
        instr(1'b1, 32'h100, 5'd3, 1'b1, 1'b0, 1'b0);
        bus.id_reg1_data = 32'h11; bus.id_reg2_data = 32'h22;
        #1;
        checks++;
        if (bus.stall_pc !== 1'b0) begin errors++; $display("FAIL capture_stall: got %b want 0", bus.stall_pc); end
        push(from_id(), "capture");
        tick();
        checks++;
        if ({bus.exe_valid, bus.exe_pc, bus.exe_reg1_data, bus.exe_reg2_data, bus.exe_write_addr, bus.exe_reg_write}
            !== {1'b1, 32'h100, 32'h11, 32'h22, 5'd3, 1'b1}) begin
            errors++; $display("FAIL capture_fields: got pc=%h r1=%h wa=%0d v=%b want pc=100 r1=11 wa=3 v=1",
                               bus.exe_pc, bus.exe_reg1_data, bus.exe_write_addr, bus.exe_valid);
        end
        checks++;
        if (bus.stall_pc !== 1'b0) begin errors++; $display("FAIL capture_stall_after: got %b want 0", bus.stall_pc); end
    endtask

    task automatic test_load_use();
        for (int s = 0; s < 3; s++) begin
            instr(1'b1, 32'h200 + 32'(s * 16), 5'(5 + s), 1'b1, 1'b1, 1'b0);
            push(from_id(), "lu_load");
            tick();
            instr(1'b1, 32'h204 + 32'(s * 16), 5'd10, s != 2, 1'b0, s == 2);
            src(s, 5'(5 + s));
            #1;
            checks++;
            if (bus.stall_pc !== 1'b1 || bus.stall_if_id !== 1'b1) begin
                errors++; $display("FAIL lu_stall src%0d: got %b%b want 11", s, bus.stall_pc, bus.stall_if_id);
            end
            bump();
            push(kill(last), "lu_bubble");
            tick();
            checks++;
            if (bus.stall_pc !== 1'b0 || bus.stall_if_id !== 1'b0) begin
                errors++; $display("FAIL lu_release src%0d: got %b%b want 00", s, bus.stall_pc, bus.stall_if_id);
            end
            push(from_id(), "lu_resume");
            tick();
        end
        checks++;
        if (bus.bubble_cnt !== 4'd3) begin errors++; $display("FAIL lu_count: got %0d want 3", bus.bubble_cnt); end
    endtask

    task automatic test_no_false();
        instr(1'b1, 32'h300, 5'd5, 1'b1, 1'b1, 1'b0);
        push(from_id(), "nf_load");
        tick();
        instr(1'b1, 32'h304, 5'd5, 1'b1, 1'b0, 1'b0);
        bus.id_reg1_addr = 5'd5; bus.id_reg2_addr = 5'd5; bus.id_sw_addr = 5'd5;
        #1;
        checks++;
        if (bus.stall_pc !== 1'b0) begin errors++; $display("FAIL nf_noread: got %b want 0", bus.stall_pc); end
        push(from_id(), "nf_noread_capture");
        tick();
        instr(1'b1, 32'h308, 5'd7, 1'b1, 1'b0, 1'b0);
        src(0, 5'd5); src(1, 5'd5);
        #1;
        checks++;
        if (bus.stall_pc !== 1'b0) begin errors++; $display("FAIL nf_alu: got %b want 0", bus.stall_pc); end
        push(from_id(), "nf_alu_capture");
        tick();
    endtask

    task automatic test_flush();
        instr(1'b1, 32'h400, 5'd9, 1'b1, 1'b1, 1'b0);
        push(from_id(), "fl_load");
        tick();
        instr(1'b1, 32'h404, 5'd11, 1'b0, 1'b0, 1'b1);
        src(0, 5'd9);
        bus.flush = 1'b1;
        #1;
        checks++;
        if (bus.stall_pc !== 1'b0 || bus.stall_if_id !== 1'b0) begin
            errors++; $display("FAIL fl_lu_stall: got %b%b want 00", bus.stall_pc, bus.stall_if_id);
        end
        push(kill(last), "fl_kill");
        tick();
        bus.flush = 1'b0;
        push(from_id(), "fl_after");
        tick();
        bus.exe_stall = 1'b1; bus.flush = 1'b1;
        #1;
        checks++;
        if (bus.stall_pc !== 1'b0) begin errors++; $display("FAIL fl_over_stall: got %b want 0", bus.stall_pc); end
        push(kill(last), "fl_over_stall_kill");
        tick();
        checks++;
        if (bus.exe_valid !== 1'b0 || bus.exe_dm_write !== 1'b0) begin
            errors++; $display("FAIL fl_ctrl: got v=%b dw=%b want 0 0", bus.exe_valid, bus.exe_dm_write);
        end
        bus.exe_stall = 1'b0; bus.flush = 1'b0;
    endtask

    task automatic test_downstream_stall();
        instr(1'b1, 32'h500, 5'd12, 1'b1, 1'b0, 1'b0);
        push(from_id(), "ds_first");
        tick();
        bus.exe_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            instr(1'b1, 32'h600 + 32'(i * 4), 5'(13 + i), 1'b1, 1'b0, 1'b1);
            #1;
            checks++;
            if (bus.stall_pc !== 1'b1 || bus.stall_if_id !== 1'b1) begin
                errors++; $display("FAIL ds_stall %0d: got %b%b want 11", i, bus.stall_pc, bus.stall_if_id);
            end
            push(last, "ds_hold");
            tick();
        end
        bus.exe_stall = 1'b0;
        push(from_id(), "ds_resume");
        tick();
        instr(1'b1, 32'h700, 5'd5, 1'b1, 1'b1, 1'b0);
        push(from_id(), "ds_load");
        tick();
        instr(1'b1, 32'h704, 5'd14, 1'b1, 1'b0, 1'b0);
        src(1, 5'd5);
        bus.exe_stall = 1'b1;
        push(last, "ds_lu_hold_nocount");
        tick();
        bus.exe_stall = 1'b0;
        #1;
        checks++;
        if (bus.stall_pc !== 1'b1) begin errors++; $display("FAIL ds_lu_stall: got %b want 1", bus.stall_pc); end
        bump();
        push(kill(last), "ds_lu_bubble");
        tick();
        push(from_id(), "ds_lu_resume");
        tick();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) begin
            instr(1'($urandom_range(0, 1)), $urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                  1'b0, 1'($urandom_range(0, 1)));
            src(int'($urandom_range(0, 2)), 5'($urandom_range(0, 31)));
            #1;
            checks++;
            if (bus.stall_pc !== 1'b0) begin errors++; $display("FAIL b2b_stall %0d: got %b want 0", i, bus.stall_pc); end
            push(from_id(), "b2b");
            tick();
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 18; i++) begin
            instr(1'b1, 32'h800, 5'd5, 1'b1, 1'b1, 1'b0);
            src(0, 5'd5);
            push(from_id(), "sat_load");
            tick();
            checks++;
            if (bus.stall_pc !== 1'b1) begin errors++; $display("FAIL sat_stall %0d: got %b want 1", i, bus.stall_pc); end
            bump();
            push(kill(last), "sat_bubble");
            tick();
        end
        checks++;
        if (bus.bubble_cnt !== 4'hF) begin errors++; $display("FAIL sat_value: got %h want f", bus.bubble_cnt); end
        rst = 1'b1;
        tick();
        checks++;
        if (obs() !== '0) begin errors++; $display("FAIL sat_reset: got %h want 0", obs()); end
        checks++;
        if (bus.stall_pc !== 1'b0) begin errors++; $display("FAIL sat_reset_stall: got %b want 0", bus.stall_pc); end
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_capture();
        test_load_use();
        test_no_false();
        test_flush();
        test_downstream_stall();
        test_back_to_back();
        test_saturation();
        tick();
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_drain: got %0d want 0", sb.size()); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
